me_search_ctrl: RTL

- Sequences the SAD datapath across a full 16x16 integer-pel search window for one 8x8 current block.
- Each step fetches one candidate row (16 horizontal offsets) into the SAD datapath input and fires one SAD computation.
- Collects 16 SADs per row and tracks the running minimum SAD and its motion vector.
- Sits between the ME top-level sequencer (start/done) and the reference fetch unit plus SAD datapath.

---
 rtl/me_search_ctrl_pkg.sv | 29 ++
 rtl/me_search_ctrl_if.sv | 47 ++++
 rtl/me_search_ctrl_sad_min16.sv | 42 ++++
 rtl/me_search_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/me_search_ctrl_pkg.sv
// Shared types and sizes for the motion-estimation search controller.
// Optional early termination is enabled by defining ME_EARLY_TERM_EN.
package me_pkg;

    localparam int N_POS = 16;
    localparam int SAD_W = 16;
    localparam int MV_W  = 5;
    localparam int ROW_W = $clog2(N_POS);

    localparam logic [SAD_W-1:0] SAD_MAX = '1;

    typedef logic [ROW_W-1:0] row_t;
    typedef logic [SAD_W-1:0] sad_t;
    typedef logic [MV_W-1:0]  mv_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CALC  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Offset index 0..N_POS-1 maps to a signed vector -N_POS/2 .. N_POS/2-1.
    function automatic mv_t idx_to_mv(row_t idx);
        return mv_t'({1'b0, idx}) - mv_t'(N_POS / 2);
    endfunction

endpackage

// File: rtl/me_search_ctrl_if.sv
// Control, fetch and SAD-result signals of the search controller.
// The early-termination threshold/flag exist only with ME_EARLY_TERM_EN.
interface me_search_ctrl_if;
    import me_pkg::*;

    // Handshakes: ref_rd_req stays high until ref_rd_ack is sampled high on a
    // rising edge while req is high; sad_en is a single-cycle request and
    // sad_vld (any later cycle) is the response, seen only while waiting for it.
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    ref_rd_req;
    row_t                    ref_rd_row;
    logic                    ref_rd_ack;
    logic                    sad_en;
    logic                    sad_vld;
    logic [N_POS*SAD_W-1:0]  sad_row;
    sad_t                    best_sad;
    mv_t                     best_mv_x;
    mv_t                     best_mv_y;
    state_t                  state_dbg;
`ifdef ME_EARLY_TERM_EN
    sad_t                    et_thresh;
    logic                    early_term;
`endif

    modport master (
        input  start, ref_rd_ack, sad_vld, sad_row,
`ifdef ME_EARLY_TERM_EN
        input  et_thresh,
        output early_term,
`endif
        output busy, done, ref_rd_req, ref_rd_row, sad_en,
        output best_sad, best_mv_x, best_mv_y, state_dbg
    );

    modport slave (
        output start, ref_rd_ack, sad_vld, sad_row,
`ifdef ME_EARLY_TERM_EN
        output et_thresh,
        input  early_term,
`endif
        input  busy, done, ref_rd_req, ref_rd_row, sad_en,
        input  best_sad, best_mv_x, best_mv_y, state_dbg
    );

endinterface

// File: rtl/me_search_ctrl_sad_min16.sv
// Combinational argmin over one row of N_POS SADs; lowest column wins ties.
module sad_min16
    import me_pkg::*;
(
    input  logic [N_POS*SAD_W-1:0] sad_row,
    output sad_t                   min_sad,
    output row_t                   min_idx
);

    localparam int LVLS = $clog2(N_POS);

    sad_t val [LVLS+1][N_POS];
    row_t idx [LVLS+1][N_POS];

    always_comb begin
        for (int l = 0; l <= LVLS; l++) begin
            for (int i = 0; i < N_POS; i++) begin
                val[l][i] = '0;
                idx[l][i] = '0;
            end
        end
        for (int i = 0; i < N_POS; i++) begin
            val[0][i] = sad_row[i*SAD_W +: SAD_W];
            idx[0][i] = row_t'(i);
        end
        // The left operand always covers lower columns, so it keeps ties.
        for (int l = 1; l <= LVLS; l++) begin
            for (int i = 0; i < (N_POS >> l); i++) begin
                if (val[l-1][2*i+1] < val[l-1][2*i]) begin
                    val[l][i] = val[l-1][2*i+1];
                    idx[l][i] = idx[l-1][2*i+1];
                end else begin
                    val[l][i] = val[l-1][2*i];
                    idx[l][i] = idx[l-1][2*i];
                end
            end
        end
        min_sad = val[LVLS][0];
        min_idx = idx[LVLS][0];
    end

endmodule

// File: rtl/me_search_ctrl.sv
// Full-window integer-pel search sequencer: fetch row, fire SAD, track minimum.
// Define ME_EARLY_TERM_EN to stop once the best SAD is at or below et_thresh.
module me_search_ctrl
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    me_search_ctrl_if.master bus
);

    state_t state;
    row_t   row;
    logic   busy_q, done_q, req_q, sad_en_q;
    sad_t   best_sad_q;
    mv_t    mv_x_q, mv_y_q;

    sad_t   rowmin;
    row_t   mincol;
    logic   better;
    sad_t   upd_best;
    logic   et_hit;

    sad_min16 u_min (
        .sad_row (bus.sad_row),
        .min_sad (rowmin),
        .min_idx (mincol)
    );

    // Strict less-than keeps the earliest raster position on cross-row ties.
    assign better   = rowmin < best_sad_q;
    assign upd_best = better ? rowmin : best_sad_q;

`ifdef ME_EARLY_TERM_EN
    logic early_q;
    assign et_hit         = upd_best <= bus.et_thresh;
    assign bus.early_term = early_q;
`else
    assign et_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            req_q      <= 1'b0;
            sad_en_q   <= 1'b0;
            best_sad_q <= SAD_MAX;
            mv_x_q     <= '0;
            mv_y_q     <= '0;
`ifdef ME_EARLY_TERM_EN
            early_q    <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            sad_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= FETCH;
                        row        <= '0;
                        busy_q     <= 1'b1;
                        req_q      <= 1'b1;
                        best_sad_q <= SAD_MAX;
                        mv_x_q     <= '0;
                        mv_y_q     <= '0;
`ifdef ME_EARLY_TERM_EN
                        early_q    <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (bus.ref_rd_ack) begin
                        req_q    <= 1'b0;
                        sad_en_q <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.sad_vld) begin
                        if (better) begin
                            best_sad_q <= rowmin;
                            mv_x_q     <= idx_to_mv(mincol);
                            mv_y_q     <= idx_to_mv(row);
                        end
                        if (row == row_t'(N_POS - 1) || et_hit) begin
                            state  <= DONE;
                            done_q <= 1'b1;
`ifdef ME_EARLY_TERM_EN
                            early_q <= et_hit;
`endif
                        end else begin
                            row   <= row + 1'b1;
                            req_q <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    req_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ref_rd_req = req_q;
    assign bus.ref_rd_row = row;
    assign bus.sad_en     = sad_en_q;
    assign bus.best_sad   = best_sad_q;
    assign bus.best_mv_x  = mv_x_q;
    assign bus.best_mv_y  = mv_y_q;
    assign bus.state_dbg  = state;

endmodule
